// File: rtl/tag_ram_ctrl.sv
// tag_ram_ctrl: initiator-side controller for a 2^AW x DW 1R1W synchronous
// tag RAM. Clears every entry after reset or on flush, then serves a lookup
// port (fixed one-cycle response latency) and an update port.
// Optional build macro: TAG_RAM_CTRL_BYPASS_EN -- forward update data to a
// lookup of the same address in the same cycle instead of stalling it.
module tag_ram_ctrl #(
    parameter int unsigned   AW          = 7,
    parameter int unsigned   DW          = 23,
    parameter logic [DW-1:0] CLEAR_VALUE = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lkp_valid,
    output logic          lkp_ready,
    input  logic [AW-1:0] lkp_addr,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    input  logic          upd_valid,
    output logic          upd_ready,
    input  logic [AW-1:0] upd_addr,
    input  logic [DW-1:0] upd_data,
    input  logic          flush_req,
    output logic          busy,
    output logic [AW-1:0] ram_raddr,
    output logic          ram_re,
    input  logic [DW-1:0] ram_rd,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wr,
    output logic          ram_we
);

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          collide;
    logic          lkp_fire;

    // Next-state, sweep counter and all RAM/handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lkp_ready = 1'b0;
        upd_ready = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = upd_addr;
        ram_wr    = upd_data;
        collide   = lkp_valid && upd_valid && (lkp_addr == upd_addr);
        unique case (state_q)
            SWEEP: begin
                // rst gates the write so no clear is issued while reset is held
                ram_we    = !rst;
                ram_waddr = cnt_q;
                ram_wr    = CLEAR_VALUE;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (flush_req) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end else begin
                    upd_ready = 1'b1;
`ifdef TAG_RAM_CTRL_BYPASS_EN
                    lkp_ready = 1'b1;
`else
                    lkp_ready = !collide;
`endif
                    ram_we    = upd_valid;
                end
            end
        endcase
        lkp_fire    = lkp_valid && lkp_ready;
        rsp_valid_d = lkp_fire;
    end

    assign ram_re    = lkp_fire;
    assign ram_raddr = lkp_addr;
    assign busy      = (state_q == SWEEP);
    assign rsp_valid = rsp_valid_q;

    // State, sweep counter and response-valid registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SWEEP;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

`ifdef TAG_RAM_CTRL_BYPASS_EN
    logic          fwd_q, fwd_d;
    logic [DW-1:0] fwd_data_q, fwd_data_d;

    // Forward select only changes on an accepted lookup so rsp_data holds when idle.
    always_comb begin
        fwd_d      = fwd_q;
        fwd_data_d = fwd_data_q;
        if (lkp_fire) begin
            fwd_d = collide;
            if (collide) begin
                fwd_data_d = upd_data;
            end
        end
    end

    // Forward flag and captured update data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_q      <= fwd_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign rsp_data = fwd_q ? fwd_data_q : ram_rd;
`else
    assign rsp_data = ram_rd;
`endif

endmodule

// File: tb/tb_tag_ram_ctrl.sv
// Self-checking bench for tag_ram_ctrl: table-driven vectors plus hand-written
// sweep/flush/reset sequences, with a response scoreboard queue.
module tb_tag_ram_ctrl;

    localparam int AW = 7;
    localparam int DW = 23;
`ifdef TAG_RAM_CTRL_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lkp_valid = 1'b0;
    logic          lkp_ready;
    logic [AW-1:0] lkp_addr = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          upd_valid = 1'b0;
    logic          upd_ready;
    logic [AW-1:0] upd_addr = '0;
    logic [DW-1:0] upd_data = '0;
    logic          flush_req = 1'b0;
    logic          busy;
    logic [AW-1:0] ram_raddr;
    logic          ram_re;
    logic [DW-1:0] ram_rd = '0;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wr;
    logic          ram_we;

    always #5 clk = ~clk;

    tag_ram_ctrl #(.AW(AW), .DW(DW), .CLEAR_VALUE('0)) dut (
        .clk(clk), .rst(rst),
        .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_addr(lkp_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr), .upd_data(upd_data),
        .flush_req(flush_req), .busy(busy),
        .ram_raddr(ram_raddr), .ram_re(ram_re), .ram_rd(ram_rd),
        .ram_waddr(ram_waddr), .ram_wr(ram_wr), .ram_we(ram_we)
    );

    // Behavioural 1R1W RAM: registered read, read-before-write on same address.
    logic [DW-1:0] ram_mem [1<<AW];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_waddr] <= ram_wr;
        if (ram_re) ram_rd <= ram_mem[ram_raddr];
    end

    typedef struct {
        logic          lv;
        logic [AW-1:0] la;
        logic          uv;
        logic [AW-1:0] ua;
        logic [DW-1:0] ud;
        logic          fl;
        logic          elr;
        logic          eur;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] model [1<<AW];
    logic [DW-1:0] exp_q[$];
    logic          pend = 1'b0;
    int            n_cmp = 0;
    int            n_err = 0;

    function automatic vec_t mk(logic lv, logic [AW-1:0] la, logic uv, logic [AW-1:0] ua,
                                logic [DW-1:0] ud, logic fl, logic elr, logic eur);
        vec_t v;
        v.lv = lv; v.la = la; v.uv = uv; v.ua = ua; v.ud = ud; v.fl = fl;
        v.elr = elr; v.eur = eur;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        lkp_valid = 1'b0; upd_valid = 1'b0; flush_req = 1'b0;
    endtask

    // One clock: check the response that pend predicted for this cycle.
    task automatic step(input string nm);
        logic [DW-1:0] e;
        @(posedge clk); #1;
        chk({nm, "_rspv"}, 64'(rsp_valid), 64'(pend));
        if (pend) begin
            if (exp_q.size() == 0) begin
                chk({nm, "_sb_empty"}, 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk({nm, "_rspd"}, 64'(rsp_data), 64'(e));
            end
        end
        pend = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        logic lf, uf;
        lkp_valid = v.lv; lkp_addr = v.la;
        upd_valid = v.uv; upd_addr = v.ua; upd_data = v.ud;
        flush_req = v.fl;
        #1;
        lf = v.lv && v.elr;
        uf = v.uv && v.eur;
        chk({nm, "_rdy"}, 64'({lkp_ready, upd_ready}), 64'({v.elr, v.eur}));
        chk({nm, "_re_we"}, 64'({ram_re, ram_we}), 64'({lf, uf}));
        if (lf) chk({nm, "_raddr"}, 64'(ram_raddr), 64'(v.la));
        if (uf) chk({nm, "_wport"}, 64'({ram_waddr, ram_wr}), 64'({v.ua, v.ud}));
        if (lf) begin
            if (BYP && uf && (v.ua == v.la)) exp_q.push_back(v.ud);
            else exp_q.push_back(model[v.la]);
        end
        if (uf) model[v.ua] = v.ud;
        pend = lf;
        step(nm);
        idle();
    endtask

    // Runs ncyc sweep cycles with traffic presented (and rejected); full sweeps
    // also check the hand-over to RUN right after address 2^AW-1.
    task automatic sweep_check(input int ncyc, input int flush_at);
        for (int i = 0; i < (1 << AW); i++) model[i] = '0;
        for (int i = 0; i < ncyc; i++) begin
            lkp_valid = 1'b1; lkp_addr = 7'(i);
            upd_valid = 1'b1; upd_addr = 7'(i + 3); upd_data = 23'h7ABCDE;
            flush_req = (i == flush_at);
            #1;
            chk("sweep_cyc",
                64'({busy, lkp_ready, upd_ready, ram_re, ram_we, ram_waddr, ram_wr}),
                64'({5'b10001, 7'(i), 23'd0}));
            step("sweep");
        end
        idle();
        if (ncyc == (1 << AW)) begin
            #1;
            chk("sweep_end", 64'({busy, lkp_ready, upd_ready}), 64'(3'b011));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram_mem[i] = '1;

        // Reset values while rst is held.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_vals", 64'({busy, lkp_ready, upd_ready, rsp_valid, ram_re, ram_we}),
            64'(6'b100000));
        rst = 1'b0;
        sweep_check(1 << AW, -1);

        // Main table: normal traffic, back-to-back, different-address pair, collision.
        vecs.push_back(mk(1, 7'h05, 0, 7'h00, 23'h0,      0, 1, 1));
        vecs.push_back(mk(0, 7'h00, 1, 7'h12, 23'h5A5A5A, 0, 1, 1));
        vecs.push_back(mk(1, 7'h12, 0, 7'h00, 23'h0,      0, 1, 1));
        vecs.push_back(mk(0, 7'h00, 1, 7'h01, 23'h111111, 0, 1, 1));
        vecs.push_back(mk(0, 7'h00, 1, 7'h02, 23'h222222, 0, 1, 1));
        vecs.push_back(mk(0, 7'h00, 1, 7'h03, 23'h333333, 0, 1, 1));
        vecs.push_back(mk(1, 7'h01, 0, 7'h00, 23'h0,      0, 1, 1));
        vecs.push_back(mk(1, 7'h02, 0, 7'h00, 23'h0,      0, 1, 1));
        vecs.push_back(mk(1, 7'h03, 0, 7'h00, 23'h0,      0, 1, 1));
        vecs.push_back(mk(1, 7'h20, 1, 7'h21, 23'h0ABCDE, 0, 1, 1));
        vecs.push_back(mk(1, 7'h40, 1, 7'h40, 23'h7FFFFF, 0, BYP, 1));
        vecs.push_back(mk(1, 7'h40, 0, 7'h00, 23'h0,      0, 1, 1));
        vecs.push_back(mk(1, 7'h21, 0, 7'h00, 23'h0,      0, 1, 1));
        vecs.push_back(mk(0, 7'h00, 1, 7'h33, 23'h123456, 0, 1, 1));
        vecs.push_back(mk(0, 7'h00, 0, 7'h00, 23'h0,      0, 1, 1));
        foreach (vecs[k]) run_vec(vecs[k], $sformatf("vec%0d", k));

        // rsp_data holds its last value through idle cycles.
        run_vec(mk(1, 7'h12, 0, 7'h00, 23'h0, 0, 1, 1), "hold_lkp");
        run_vec(mk(0, 7'h00, 0, 7'h00, 23'h0, 0, 1, 1), "hold_idle");
        chk("hold_data", 64'(rsp_data), 64'(23'h5A5A5A));

        // Flush with a response in flight and traffic presented in the flush cycle;
        // a second flush pulse at sweep cycle 50 must not extend the sweep.
        run_vec(mk(1, 7'h33, 0, 7'h00, 23'h0,      0, 1, 1), "pre_flush");
        run_vec(mk(1, 7'h05, 1, 7'h06, 23'h654321, 1, 0, 0), "flush");
        sweep_check(1 << AW, 50);
        run_vec(mk(1, 7'h33, 0, 7'h00, 23'h0, 0, 1, 1), "post_flush");
        run_vec(mk(0, 7'h00, 0, 7'h00, 23'h0, 0, 1, 1), "post_idle");

        // Reset asserted at sweep cycle 60, then a complete restarted sweep.
        run_vec(mk(0, 7'h00, 0, 7'h00, 23'h0, 1, 0, 0), "flush2");
        sweep_check(60, -1);
        rst = 1'b1;
        #1;
        chk("rst_mid", 64'({busy, lkp_ready, upd_ready, rsp_valid, ram_re, ram_we}),
            64'(6'b100000));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold", 64'({busy, ram_we, ram_waddr}), 64'({2'b10, 7'd0}));
        rst = 1'b0;
        sweep_check(1 << AW, -1);
        run_vec(mk(1, 7'h12, 0, 7'h00, 23'h0, 0, 1, 1), "post_rst");
        run_vec(mk(0, 7'h00, 0, 7'h00, 23'h0, 0, 1, 1), "final_idle");
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tag_ram_ctrl.md
Name: tag_ram_ctrl

Overview:
- Initiator-side controller for the 128x23 1R1W synchronous tag/metadata RAM; it drives that RAM's read and write ports.
- Presents a lookup port (valid/ready request, fixed-latency response) and an update port (valid/ready) to the cache pipeline.
- After reset, or on a flush request, it sweeps every entry to CLEAR_VALUE before accepting traffic.

Parameters:
- AW, 7, RAM address width; depth is 2^AW.
- DW, 23, RAM data width.
- CLEAR_VALUE, 0, DW-bit value written to every entry during a sweep.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- lkp_valid  in  1  lookup request.
- lkp_ready  out  1  lookup accepted when valid and ready are both high.
- lkp_addr  in  AW  lookup address.
- rsp_valid  out  1  one-cycle pulse; lookup data is valid.
- rsp_data  out  DW  lookup data.
- upd_valid  in  1  update request.
- upd_ready  out  1  update accepted when valid and ready are both high.
- upd_addr  in  AW  update address.
- upd_data  in  DW  update data.
- flush_req  in  1  single-cycle pulse; starts a clear sweep.
- busy  out  1  high while a sweep is in progress.
- ram_raddr  out  AW  to RAM raddr.
- ram_re  out  1  to RAM re.
- ram_rd  in  DW  from RAM rd; registered, valid the cycle after re.
- ram_waddr  out  AW  to RAM waddr.
- ram_wr  out  DW  to RAM wr.
- ram_we  out  1  to RAM we.

Behaviour:
- State machine has two states, SWEEP and RUN.
- Reset values:
  - state = SWEEP, sweep counter = 0, busy = 1.
  - lkp_ready = 0, upd_ready = 0, rsp_valid = 0.
  - ram_re = 0, ram_we = 0.
  - rsp_data select = RAM path.
- SWEEP, each cycle:
  - ram_we = 1, ram_waddr = counter, ram_wr = CLEAR_VALUE; counter increments.
  - After the write at address 2^AW-1: go to RUN and clear busy on the next edge.
  - A sweep takes exactly 2^AW cycles (128 at default).
  - lkp_ready = 0, upd_ready = 0, ram_re = 0.
- Reset asserted mid-sweep: the counter returns to 0 and the sweep restarts after reset deasserts.
- RUN:
  - lkp_ready = 1 and upd_ready = 1, except for the collision rule below.
  - Both ports are combinationally derived from state and inputs; no extra register stage.
- Lookup:
  - An accepted lookup drives ram_re = 1 and ram_raddr = lkp_addr in the same cycle.
  - rsp_valid = 1 exactly one cycle later.
  - rsp_data = ram_rd, unless bypass applies (see Optional Feature).
  - Throughput is one lookup per cycle. There is no response backpressure.
  - rsp_data holds its last value while rsp_valid = 0 (the RAM holds rd when re = 0).
- Update:
  - An accepted update drives ram_we = 1, ram_waddr = upd_addr, ram_wr = upd_data in the same cycle.
  - The write is visible to any lookup accepted in a later cycle.
- Lookup and update to different addresses in the same cycle are both accepted.
- Same-address collision (lkp_valid && upd_valid && lkp_addr == upd_addr):
  - With macro off: update wins. lkp_ready = 0 that cycle and the lookup retries in the next cycle.
  - With macro on: see Optional Feature.
- flush_req in RUN:
  - In-flight responses complete: a lookup accepted in the previous cycle still produces its rsp_valid.
  - Next cycle: state = SWEEP, counter = 0, busy = 1.
  - Any lookup or update presented in the flush_req cycle is not accepted (ready = 0).
- flush_req during SWEEP: ignored; the sweep is not restarted.
- Counter width is AW; it wraps at 2^AW, and the wrap marks the end of the sweep.

Optional Feature:
- Macro: TAG_RAM_CTRL_BYPASS_EN.
- When defined, a same-address collision accepts both requests (lkp_ready stays 1).
  - The write proceeds as normal.
  - A forward flag and upd_data are registered.
  - On the next cycle rsp_data = the registered upd_data instead of ram_rd.
  - The RAM read result in that cycle is the pre-write data and is discarded.
- When undefined, no forwarding logic is built and the stall rule applies.

Test Plan:
- Release reset:
  - Required: busy = 1 for exactly 128 cycles.
  - Required: ram_we = 1 with ram_waddr stepping 0..127 and ram_wr = 0.
  - Required: then busy = 0 and lkp_ready = upd_ready = 1.
  - Then lookup 0x05 -> rsp_valid next cycle, rsp_data = 0x000000.
- Update addr 0x12 data 0x5A5A5A, then lookup 0x12 next cycle -> response the following cycle = 0x5A5A5A.
- Back-to-back lookups 0x01, 0x02, 0x03 (after updates of 0x111111, 0x222222, 0x333333) -> three consecutive rsp_valid pulses with data in order.
- Same-cycle update 0x40 = 0x7FFFFF and lookup 0x40:
  - Macro off -> lkp_ready = 0 that cycle; the retried lookup returns 0x7FFFFF.
  - Macro on -> accepted; response next cycle = 0x7FFFFF.
- Update 0x33 = 0x123456, then flush_req:
  - Required: busy for 128 cycles.
  - Required: lookup 0x33 afterwards returns 0x000000.
  - Required: flush_req pulsed at sweep cycle 50 does not extend the sweep.
- Assert rst at sweep cycle 60 -> all outputs return to their reset values immediately; after release the sweep restarts at address 0 and lasts 128 cycles.
